// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults and helpers for the fifo_prog family.
//   DEF_DATA_W / DEF_DEPTH : default width and depth of the FIFO.
//   fifo_aw()              : address width for a given depth.
//   fifo_cnt_t             : count/threshold type for the default depth;
//                            instances with other depths declare the same
//                            shape locally as logic [fifo_aw(DEPTH):0].
package fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;

  // Address width for a power-of-two depth.
  function automatic int fifo_aw(input int depth);
    return $clog2(depth);
  endfunction

  localparam int DEF_AW = fifo_aw(DEF_DEPTH);

  // Occupancy needs one extra bit so that 0..DEPTH is representable.
  typedef logic [DEF_AW:0] fifo_cnt_t;

endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: DEPTH x DATA_W storage for fifo_prog.
//   clk   : clock, write on posedge
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : asynchronous read data (mem[raddr])
module fifo_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // The combinational read lets FWFT present the head entry in the same
  // cycle the read pointer moves; standard mode registers it in the parent.
  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_prog.sv
// fifo_prog: single-clock FIFO with programmable almost-full/almost-empty
// thresholds, fill count, sticky error flags, synchronous flush and an
// optional first-word-fall-through read mode.
//   clk, rstn            : clock, asynchronous active-low reset
//   i_wren, i_wrdata     : write request and data
//   i_rden, o_rddata     : read request and data
//   i_flush              : synchronous empty (overrides wren/rden)
//   i_af_thr, i_ae_thr   : almost-full / almost-empty thresholds (unsigned)
//   i_clr_err            : clears o_overflow / o_underflow
//   o_full, o_alm_full, o_empty, o_alm_empty : registered status flags
//   o_count              : occupancy 0..DEPTH
//   o_overflow, o_underflow : sticky error flags
module fifo_prog
  import fifo_pkg::*;
#(
  parameter int  DATA_W = DEF_DATA_W,
  parameter int  DEPTH  = DEF_DEPTH,
  parameter bit  FWFT   = 1'b0,
  localparam int AW     = fifo_aw(DEPTH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_wren,
  input  logic [DATA_W-1:0] i_wrdata,
  input  logic              i_rden,
  output logic [DATA_W-1:0] o_rddata,
  input  logic              i_flush,
  input  logic [AW:0]       i_af_thr,
  input  logic [AW:0]       i_ae_thr,
  input  logic              i_clr_err,
  output logic              o_full,
  output logic              o_alm_full,
  output logic              o_empty,
  output logic              o_alm_empty,
  output logic [AW:0]       o_count,
  output logic              o_overflow,
  output logic              o_underflow
);

  typedef logic [AW:0] cnt_t;

  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

  cnt_t wr_ptr_reg, wr_ptr_next;
  cnt_t rd_ptr_reg, rd_ptr_next;
  cnt_t count_reg, count_next;
  logic full_reg, full_next;
  logic empty_reg, empty_next;
  logic alm_full_reg, alm_full_next;
  logic alm_empty_reg, alm_empty_next;
  logic ovf_reg, ovf_next;
  logic unf_reg, unf_next;

  logic              wr_acc;
  logic              rd_acc;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;

  // Acceptance is judged against the registered flags, so a full FIFO can
  // still take a read in the same cycle a write is refused (and vice versa).
  assign wr_acc = i_wren && !full_reg;
  assign rd_acc = i_rden && !empty_reg;
  assign ram_we = wr_acc && !i_flush;

  always_comb begin
    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    count_next     = count_reg;
    full_next      = full_reg;
    empty_next     = empty_reg;
    alm_full_next  = alm_full_reg;
    alm_empty_next = alm_empty_reg;

    if (i_flush) begin
      wr_ptr_next    = '0;
      rd_ptr_next    = '0;
      count_next     = '0;
      full_next      = 1'b0;
      empty_next     = 1'b1;
      alm_full_next  = 1'b0;
      alm_empty_next = 1'b1;
    end else begin
      if (wr_acc) begin
        wr_ptr_next = wr_ptr_reg + cnt_t'(1);
      end
      if (rd_acc) begin
        rd_ptr_next = rd_ptr_reg + cnt_t'(1);
      end
      count_next     = count_reg + cnt_t'(wr_acc) - cnt_t'(rd_acc);
      full_next      = (count_next == DEPTH_C);
      empty_next     = (count_next == '0);
      alm_full_next  = (count_next >= i_af_thr);
      alm_empty_next = (count_next <= i_ae_thr);
    end

    // A new error wins over a coincident clear; flushed requests are ignored.
    ovf_next = (ovf_reg && !i_clr_err) || (i_wren && full_reg && !i_flush);
    unf_next = (unf_reg && !i_clr_err) || (i_rden && empty_reg && !i_flush);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      full_reg      <= 1'b0;
      empty_reg     <= 1'b1;
      alm_full_reg  <= 1'b0;
      alm_empty_reg <= 1'b1;
      ovf_reg       <= 1'b0;
      unf_reg       <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      full_reg      <= full_next;
      empty_reg     <= empty_next;
      alm_full_reg  <= alm_full_next;
      alm_empty_reg <= alm_empty_next;
      ovf_reg       <= ovf_next;
      unf_reg       <= unf_next;
    end
  end

  fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr_reg[AW-1:0]),
    .wdata (i_wrdata),
    .raddr (rd_ptr_reg[AW-1:0]),
    .rdata (ram_rdata)
  );

  generate
    if (FWFT) begin : g_fwft
      // Head entry is always on the output; it is meaningless while empty.
      assign o_rddata = ram_rdata;
    end else begin : g_std
      logic [DATA_W-1:0] rddata_reg;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          rddata_reg <= '0;
        end else if (rd_acc && !i_flush) begin
          rddata_reg <= ram_rdata;
        end
      end

      assign o_rddata = rddata_reg;
    end
  endgenerate

  assign o_full      = full_reg;
  assign o_alm_full  = alm_full_reg;
  assign o_empty     = empty_reg;
  assign o_alm_empty = alm_empty_reg;
  assign o_count     = count_reg;
  assign o_overflow  = ovf_reg;
  assign o_underflow = unf_reg;

endmodule
